pipe_stage_reg: RTL

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg_if.sv | 26 ++
 rtl/pipe_stage_reg.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle between an upstream producer, one pipeline stage register
// and its downstream consumer. The master side is the producer/consumer pair
// around the stage; the slave side is the stage itself.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 12
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;

    modport master (
        output in_valid, in_data, in_ctrl, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl
    );

    modport slave (
        input  in_valid, in_data, in_ctrl, out_ready,
        output in_ready, out_valid, out_data, out_ctrl
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush, hazard hold and
// saturating stall/flush performance counters. With SKID=1 a second entry
// absorbs one beat of downstream backpressure so in_ready never depends on
// out_ready; with SKID=0 it is a plain single-entry register.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 12,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    pipe_stage_reg_if.slave  bus,
    input  logic             flush,
    input  logic             hold,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_accept;
    logic              w_consume;
    logic              w_load_main_in;
    logic              w_load_main_skid;
    logic              w_load_skid;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign w_out_valid = (r_state != ST_EMPTY);

    // Ready: the skid variant only looks at its own occupancy (no out_ready path);
    // the single-entry variant may accept into a slot being vacated this cycle.
    always_comb begin
        w_in_ready = 1'b0;
        if (SKID != 0) begin
            w_in_ready = !rst && !hold && (r_state != ST_FULL);
        end else begin
            w_in_ready = !rst && !hold && !flush && (!w_out_valid || bus.out_ready);
        end
    end

    assign w_accept  = bus.in_valid && w_in_ready;
    assign w_consume = w_out_valid && bus.out_ready;

    // Next-state and entry-movement decode; flush beats accept, consume and hold.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt    = ST_ONE;
                        w_load_main_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_consume) begin
                        w_load_main_in = 1'b1;
                    end else if (w_accept && (SKID != 0)) begin
                        w_state_nxt = ST_FULL;
                        w_load_skid = 1'b1;
                    end else if (w_consume) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_consume) begin
                        w_state_nxt      = ST_ONE;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    // Stage state and saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_EMPTY;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (flush) begin
                flush_cnt <= sat_inc(flush_cnt);
            end
            if (bus.in_valid && !w_in_ready && !flush) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
        end
    end

    // Main entry: drives the output and keeps its value across bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_data <= '0;
            r_main_ctrl <= '0;
        end else if (w_load_main_in) begin
            r_main_data <= bus.in_data;
            r_main_ctrl <= bus.in_ctrl;
        end else if (w_load_main_skid) begin
            r_main_data <= r_skid_data;
            r_main_ctrl <= r_skid_ctrl;
        end
    end

    // Skid entry: contents only matter while the state says FULL.
    always_ff @(posedge clk) begin
        if (w_load_skid) begin
            r_skid_data <= bus.in_data;
            r_skid_ctrl <= bus.in_ctrl;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = r_main_data;
    assign bus.out_ctrl  = w_out_valid ? r_main_ctrl : '0;

endmodule
